// File: rtl/uart_tx_link.sv
// uart_tx_link
// ------------
// Serial transmitter at the far end of the monitor's send handshake.
// It accepts one byte per handshake and shifts it out LSB first at a
// fixed baud: 8N1 by default, or 8E1 when parity is built in.
//
// Build option:
//   UART_TX_PARITY_EN  - inserts an even-parity bit between the data and
//                        stop bits, so a frame is 11 bits instead of 10.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (2..65535)
//
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous active-high reset
//   send_data   in   [7:0] byte to transmit, sampled only at acceptance
//   data_avail  in   producer request; the byte is valid while high
//   send_strobe out  1 = idle/ready, 0 = byte accepted and in flight
//   tx          out  serial line, idle high
//   busy        out  1 while a frame is on the line (~send_strobe)

module uart_tx_link #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] send_data,
    input  logic       data_avail,
    output logic       send_strobe,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          strobe_q, strobe_d;
    logic          armed_q, armed_d;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        strobe_d = strobe_q;
        // A low request re-arms the link at any time, even mid-frame, so a
        // producer that drops data_avail early can be served back-to-back.
        armed_d  = armed_q | ~data_avail;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        // Every non-idle state times one bit period with the baud counter.
        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                // armed_q keeps a request that is still high from the previous
                // frame from starting a second, unintended transmission.
                if (data_avail && armed_q) begin
                    shift_d  = send_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^send_data;
`endif
                    strobe_d = 1'b0;
                    tx_d     = 1'b0;
                    armed_d  = 1'b0;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        // Next bit is pre-loaded so tx changes on the boundary.
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    strobe_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                tx_d     = 1'b1;
                strobe_d = 1'b1;
            end
        endcase
    end

    // tx resets to 1 asynchronously, so a reset mid-frame releases the line at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            strobe_q <= 1'b1;
            armed_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            strobe_q <= strobe_d;
            armed_q  <= armed_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx          = tx_q;
    assign send_strobe = strobe_q;
    assign busy        = ~strobe_q;

endmodule

// File: doc/uart_tx_link.md
Name: uart_tx_link

Overview:
- Serial transmitter sitting on the far end of the monitor's send handshake (send_data / data_avail / send_strobe).
- Accepts one byte per handshake and serialises it 8N1, LSB first, onto the board's TX pin at a fixed baud.
- Drives send_strobe high when ready and low while a byte is being shifted out, which is the protocol the command-line monitor expects.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per serial bit (12 MHz / 115200); legal range 2..65535.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- send_data  in  8  byte to transmit; sampled only at acceptance
- data_avail  in  1  producer request; byte valid while high
- send_strobe  out  1  1 = idle/ready, 0 = byte accepted and in flight
- tx  out  1  serial line, idle high
- busy  out  1  1 while a frame is on the line (equals ~send_strobe)

Behaviour:
- Reset values: tx=1, send_strobe=1, busy=0, state=IDLE, armed=0, bit counter=0, baud counter=0. Reset asserted mid-frame aborts the frame immediately, with tx forced to 1 asynchronously.
- armed flag:
  - Set on any clock edge where data_avail is sampled 0.
  - Cleared on acceptance.
  - Prevents a stale data_avail, still high in the cycle after send_strobe rises, from retriggering a second transmission.
- States: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - If data_avail=1 and armed=1 at edge k: latch send_data into the shift register, send_strobe<=0, busy<=1, tx<=0, armed<=0, baud counter<=0, go to START.
  - If data_avail=1 and armed=0: stay in IDLE, no action.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=shift[0]; after CLKS_PER_BIT cycles, shift right and increment the index. After index 7 completes, go to PARITY if enabled, else STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle: send_strobe<=1, busy<=0, go to IDLE.
- Timing:
  - Frame without parity: tx falls at edge k, send_strobe rises at edge k+10*CLKS_PER_BIT.
  - Earliest next acceptance: edge k+10*CLKS_PER_BIT+1, and only if data_avail was already seen low.
- Baud counter: width ceil(log2(CLKS_PER_BIT)); counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Bit index is 3 bits.
- During a frame, changes on data_avail and send_data are ignored (the byte is already latched), except that data_avail=0 still sets armed.
- Simultaneous events:
  - data_avail sampled low on the same edge the frame ends: armed=1, no acceptance that edge.
  - data_avail rises on the very next edge: accepted.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx carries the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 11 bits; send_strobe rises at edge k+11*CLKS_PER_BIT.
- When undefined:
  - No PARITY state and no parity logic.
  - Frame is exactly 10 bits (8N1).

Test Plan:
- Basic frame, CLKS_PER_BIT=4, no parity: reset, data_avail=0 for 1 cycle, send_data=0x4F, data_avail=1.
  - tx bits, 4 cycles each: 0,1,1,1,1,0,0,1,0,1.
  - send_strobe low for exactly 40 cycles; busy mirrors it.
- Monitor-style handshake: producer drops data_avail in the cycle after seeing send_strobe=1.
  - Exactly one frame is sent; no second start bit within 20 cycles.
- Back-to-back "OK\r\n" (0x4F, 0x4B, 0x0D, 0x0A) driven by a model of the monitor's send_ok/strobing/wait_xmit handshake:
  - Four frames, in order, decode correctly.
  - Idle gap between frames is at least 1 cycle.
- Byte hold while busy: send_data changed to 0xFF and data_avail toggled mid-frame for 0x0A.
  - Transmitted bits remain 0,0,1,0,1,0,0,0,0,1.
  - No extra frame is sent.
- Reset mid-frame: assert reset during DATA bit 3 of 0x55.
  - tx=1 and send_strobe=1 immediately.
  - After release with data_avail=1 held continuously, no frame is sent until data_avail has been seen low.
- UART_TX_PARITY_EN defined, CLKS_PER_BIT=4, byte 0x4F:
  - Parity bit 1 appears after data bit 7.
  - send_strobe low for 44 cycles.
  - Byte 0x03 gives parity bit 0.
